// File: rtl/n_stage_stall_unit.sv
// n_stage_stall_unit: hazard-driven stall/flush controller for an in-order
// pipeline of NUM_STAGES (>=5) stages. It also provides:
//   - outstanding data-memory request tracking with back-pressure when full
//   - multi-cycle decode flush after an execute-stage redirect
//   - a PC-stall watchdog
//   - saturating performance counters
//
// Ports:
//   clock, reset             rising-edge clock, async active-high reset
//   true_data_hazard         load-use hazard in decode
//   d_mem_issue_hazard       data memory cannot accept a request
//   d_mem_recv_hazard        data memory response not yet available
//   i_mem_hazard             instruction fetch not ready
//   JALR_branch_hazard       redirect resolved in execute
//   JAL_hazard               JAL redirect resolved in decode
//   d_mem_req / d_mem_resp   data request presented / response returned
//   stall[i] / flush[i]      hold / bubble for stage i register (0 = PC)
//   outstanding_count        in-flight data requests
//   stall_timeout            sticky watchdog flag
//   protocol_error           sticky: response seen with nothing outstanding
//   stall_cycles             saturating count of PC-stall cycles
//   flush_events             saturating count of cycles with any flush
//   scan                     simulation-only state dump enable

// Saturating up-counter; one instance per performance counter.
module n_stage_stall_sat_cnt #(
  parameter int W = 32
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] cnt
);
  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc && !(&cnt_q)) cnt_d = cnt_q + W'(1);
  end

  always_ff @(posedge clock or posedge reset)
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;

  assign cnt = cnt_q;
endmodule

module n_stage_stall_unit #(
  parameter  int CORE                = 0,
  parameter  int SCAN_CYCLES_MIN     = 0,
  parameter  int SCAN_CYCLES_MAX     = 1000,
  parameter  int NUM_STAGES          = 5,
  parameter  int MAX_OUTSTANDING     = 2,
  parameter  int BRANCH_FLUSH_CYCLES = 1,
  parameter  int STALL_TIMEOUT       = 1024,
  parameter  int CNT_WIDTH           = 32,
  localparam int OC_W                = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  true_data_hazard,
  input  logic                  d_mem_issue_hazard,
  input  logic                  d_mem_recv_hazard,
  input  logic                  i_mem_hazard,
  input  logic                  JALR_branch_hazard,
  input  logic                  JAL_hazard,
  input  logic                  d_mem_req,
  input  logic                  d_mem_resp,
  output logic [NUM_STAGES-1:0] stall,
  output logic [NUM_STAGES-1:0] flush,
  output logic [OC_W-1:0]       outstanding_count,
  output logic                  stall_timeout,
  output logic                  protocol_error,
  output logic [CNT_WIDTH-1:0]  stall_cycles,
  output logic [CNT_WIDTH-1:0]  flush_events,
  input  logic                  scan
);
  localparam int MEM   = NUM_STAGES - 2;
  localparam int WB    = NUM_STAGES - 1;
  localparam int EXT_W = (BRANCH_FLUSH_CYCLES > 1) ? $clog2(BRANCH_FLUSH_CYCLES) : 1;
  localparam int WD_W  = $clog2(STALL_TIMEOUT + 1);

  localparam logic [OC_W-1:0]  OC_MAX   = OC_W'(MAX_OUTSTANDING);
  localparam logic [EXT_W-1:0] EXT_LOAD = EXT_W'(BRANCH_FLUSH_CYCLES - 1);
  localparam logic [WD_W-1:0]  WD_MAX   = WD_W'(STALL_TIMEOUT);

  logic [OC_W-1:0]  oc_q, oc_d;
  logic [EXT_W-1:0] ext_q, ext_d;
  logic [WD_W-1:0]  wd_q, wd_d;
  logic             to_q, to_d;
  logic             perr_q, perr_d;
  logic [31:0]      cyc_q, cyc_d;

  logic full_block, mem_hold, redirect, accept, retire;
  logic [NUM_STAGES-1:0] stall_raw, flush_raw;

  // A request at a full tracker is blocked unless a response frees a slot
  // in the same cycle.
  assign full_block = d_mem_req & (oc_q == OC_MAX) & ~d_mem_resp;
  assign mem_hold   = d_mem_issue_hazard | d_mem_recv_hazard | full_block;
  assign redirect   = JALR_branch_hazard | (ext_q != '0);
  assign accept     = d_mem_req & ~d_mem_issue_hazard & ~full_block;
  assign retire     = d_mem_resp & (oc_q != '0);

  // Priority resolution; a lower-priority hazard simply waits, since the
  // stage holding it is either frozen or replayed.
  always_comb begin
    stall_raw = '0;
    flush_raw = '0;
    if (mem_hold) begin
      for (int i = 0; i <= MEM; i++) stall_raw[i] = 1'b1;
      flush_raw[WB] = 1'b1;
    end else if (redirect) begin
      flush_raw[1] = 1'b1;
      flush_raw[2] = JALR_branch_hazard;
    end else if (true_data_hazard) begin
      stall_raw[1:0] = 2'b11;
      flush_raw[2]   = 1'b1;
    end else if (JAL_hazard || i_mem_hazard) begin
      flush_raw[1] = 1'b1;
      stall_raw[0] = i_mem_hazard;
    end
  end

  // Outputs are forced idle while reset is held.
  assign stall = reset ? '0 : stall_raw;
  assign flush = reset ? '0 : flush_raw;

  always_comb begin
    // Extension counter freezes under mem_hold so the flush window is not
    // consumed while the pipeline is frozen.
    ext_d = ext_q;
    if (JALR_branch_hazard && !mem_hold)  ext_d = EXT_LOAD;
    else if (ext_q != '0 && !mem_hold)    ext_d = ext_q - EXT_W'(1);

    oc_d = oc_q;
    case ({accept, retire})
      2'b10:   oc_d = oc_q + OC_W'(1);
      2'b01:   oc_d = oc_q - OC_W'(1);
      default: oc_d = oc_q;
    endcase
    perr_d = perr_q | (d_mem_resp & (oc_q == '0));

    // Watchdog run length saturates at the threshold; the flag latches the
    // cycle the run reaches it and shows from the following cycle.
    wd_d = '0;
    if (stall_raw[0]) wd_d = (wd_q == WD_MAX) ? wd_q : wd_q + WD_W'(1);
    to_d = to_q | (wd_d == WD_MAX);

    cyc_d = cyc_q + 32'd1;
  end

  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      oc_q   <= '0;
      ext_q  <= '0;
      wd_q   <= '0;
      to_q   <= 1'b0;
      perr_q <= 1'b0;
      cyc_q  <= '0;
    end else begin
      oc_q   <= oc_d;
      ext_q  <= ext_d;
      wd_q   <= wd_d;
      to_q   <= to_d;
      perr_q <= perr_d;
      cyc_q  <= cyc_d;
    end

  assign outstanding_count = oc_q;
  assign stall_timeout     = to_q;
  assign protocol_error    = perr_q;

  // Perf counters: [0] PC-stall cycles, [1] cycles with any flush.
  logic [1:0]                perf_inc;
  logic [1:0][CNT_WIDTH-1:0] perf_cnt;
  assign perf_inc = {|flush_raw, stall_raw[0]};

  for (genvar g = 0; g < 2; g++) begin : g_perf
    n_stage_stall_sat_cnt #(.W(CNT_WIDTH)) u_cnt (
      .clock (clock),
      .reset (reset),
      .inc   (perf_inc[g]),
      .cnt   (perf_cnt[g])
    );
  end

  assign stall_cycles = perf_cnt[0];
  assign flush_events = perf_cnt[1];

`ifndef SYNTHESIS
  // Simulation-only state dump inside the scan window.
  always @(posedge clock)
    if (!reset && scan && cyc_q >= 32'(SCAN_CYCLES_MIN) && cyc_q <= 32'(SCAN_CYCLES_MAX))
      $display("core %0d cyc %0d tdh=%b iss=%b rcv=%b imem=%b jalr=%b jal=%b req=%b rsp=%b stall=%b flush=%b oc=%0d",
               CORE, cyc_q, true_data_hazard, d_mem_issue_hazard, d_mem_recv_hazard,
               i_mem_hazard, JALR_branch_hazard, JAL_hazard, d_mem_req, d_mem_resp,
               stall, flush, oc_q);
`endif
endmodule

// File: tb/tb_n_stage_stall_unit.sv
// Scoreboard bench for n_stage_stall_unit: a driver issues one input vector
// per cycle and pushes the reference model's expected response; a monitor on
// the falling edge pops and compares every output.
module tb_n_stage_stall_unit;
  localparam int NS   = 5;
  localparam int MO   = 2;
  localparam int BFC  = 3;
  localparam int TO   = 8;
  localparam int CW   = 4;
  localparam int MEM  = NS - 2;
  localparam int WB   = NS - 1;
  localparam int CMAX = (1 << CW) - 1;
  localparam int OCW  = $clog2(MO + 1);

  // Stimulus vector bit map
  localparam logic [7:0] TDH = 8'h80, ISS = 8'h40, RCV = 8'h20, IMEM = 8'h10,
                         JALR = 8'h08, JAL = 8'h04, REQ = 8'h02, RSP = 8'h01;

  logic clock = 1'b0, reset = 1'b0;
  logic true_data_hazard = 0, d_mem_issue_hazard = 0, d_mem_recv_hazard = 0;
  logic i_mem_hazard = 0, JALR_branch_hazard = 0, JAL_hazard = 0;
  logic d_mem_req = 0, d_mem_resp = 0, scan = 0;
  logic [NS-1:0]  stall, flush;
  logic [OCW-1:0] outstanding_count;
  logic           stall_timeout, protocol_error;
  logic [CW-1:0]  stall_cycles, flush_events;

  n_stage_stall_unit #(
    .CORE(0), .SCAN_CYCLES_MIN(0), .SCAN_CYCLES_MAX(1000), .NUM_STAGES(NS),
    .MAX_OUTSTANDING(MO), .BRANCH_FLUSH_CYCLES(BFC), .STALL_TIMEOUT(TO), .CNT_WIDTH(CW)
  ) dut (
    .clock(clock), .reset(reset),
    .true_data_hazard(true_data_hazard), .d_mem_issue_hazard(d_mem_issue_hazard),
    .d_mem_recv_hazard(d_mem_recv_hazard), .i_mem_hazard(i_mem_hazard),
    .JALR_branch_hazard(JALR_branch_hazard), .JAL_hazard(JAL_hazard),
    .d_mem_req(d_mem_req), .d_mem_resp(d_mem_resp),
    .stall(stall), .flush(flush), .outstanding_count(outstanding_count),
    .stall_timeout(stall_timeout), .protocol_error(protocol_error),
    .stall_cycles(stall_cycles), .flush_events(flush_events), .scan(scan)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [NS-1:0] stall;
    logic [NS-1:0] flush;
    int            oc;
    bit            to;
    bit            pe;
    int            sc;
    int            fe;
  } exp_t;

  exp_t exp_q[$];
  int n_chk = 0, n_pass = 0;

  // Reference model state, plain integers
  int m_oc, m_ext, m_wd, m_sc, m_fe;
  bit m_to, m_pe;

  task automatic model_reset();
    m_oc = 0; m_ext = 0; m_wd = 0; m_sc = 0; m_fe = 0; m_to = 0; m_pe = 0;
  endtask

  // Expected outputs for this cycle from current model state, then advance
  // the model across the next rising edge.
  task automatic model_eval(input logic [7:0] v, output exp_t e);
    bit tdh, iss, rcv, imem, jalr, jal, req, rsp, full, mh, acc, ret;
    {tdh, iss, rcv, imem, jalr, jal, req, rsp} = v;
    full = req && (m_oc == MO) && !rsp;
    mh   = iss || rcv || full;
    e.stall = '0;
    e.flush = '0;
    if (mh) begin
      e.stall = NS'((1 << (MEM + 1)) - 1);
      e.flush = NS'(1 << WB);
    end else if (jalr || m_ext > 0) begin
      e.flush = jalr ? NS'(6) : NS'(2);
    end else if (tdh) begin
      e.stall = NS'(3);
      e.flush = NS'(4);
    end else if (jal || imem) begin
      e.flush = NS'(2);
      e.stall = imem ? NS'(1) : NS'(0);
    end
    e.oc = m_oc; e.to = m_to; e.pe = m_pe; e.sc = m_sc; e.fe = m_fe;

    if (jalr && !mh)           m_ext = BFC - 1;
    else if (m_ext > 0 && !mh) m_ext = m_ext - 1;
    acc = req && !iss && !full;
    ret = rsp && (m_oc > 0);
    if (rsp && m_oc == 0) m_pe = 1;
    m_oc = m_oc + int'(acc) - int'(ret);
    if (e.stall[0]) begin
      m_wd++;
      if (m_wd >= TO) m_to = 1;
    end else m_wd = 0;
    if (e.stall[0] && m_sc < CMAX) m_sc++;
    if (e.flush != 0 && m_fe < CMAX) m_fe++;
  endtask

  // One cycle of stimulus. With rst set, reset is pulsed high mid-cycle
  // (no clock edge in between) and the expected outputs are all idle.
  task automatic step(input logic [7:0] v, input bit rst = 1'b0);
    exp_t e;
    @(posedge clock);
    #1;
    {true_data_hazard, d_mem_issue_hazard, d_mem_recv_hazard, i_mem_hazard,
     JALR_branch_hazard, JAL_hazard, d_mem_req, d_mem_resp} = v;
    reset = 1'b0;
    if (rst) begin
      #2;
      reset = 1'b1;
      model_reset();
      e.stall = '0; e.flush = '0;
      e.oc = 0; e.to = 0; e.pe = 0; e.sc = 0; e.fe = 0;
    end else begin
      model_eval(v, e);
    end
    exp_q.push_back(e);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_chk++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, expv, $time);
  endtask

  // Monitor: outputs are valid every cycle, compared on the falling edge.
  always @(negedge clock) begin : mon
    exp_t e;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk("stall",             32'(stall),             32'(e.stall));
      chk("flush",             32'(flush),             32'(e.flush));
      chk("outstanding_count", 32'(outstanding_count), e.oc);
      chk("stall_timeout",     32'(stall_timeout),     32'(e.to));
      chk("protocol_error",    32'(protocol_error),    32'(e.pe));
      chk("stall_cycles",      32'(stall_cycles),      e.sc);
      chk("flush_events",      32'(flush_events),      e.fe);
    end
  end

  initial begin
    #200000;
    $display("FAIL time_limit: simulation did not finish, required finish before 200000");
    $fatal(1);
  end

  initial begin
    logic [7:0] v;
    model_reset();
    // Reset state
    step(8'h00, 1'b1);
    step(8'h00, 1'b1);
    step(8'h00);
    step(8'h00);
    // Priority cases
    step(TDH | ISS);
    step(TDH | JALR);
    repeat (3) step(8'h00);
    step(TDH | JAL);
    step(IMEM);
    step(8'h00);
    // Outstanding back-pressure and protocol error
    step(REQ);
    step(REQ);
    step(REQ);
    step(REQ | RSP);
    step(RSP);
    step(RSP);
    step(RSP);
    step(8'h00);
    // Branch flush extension, with a memory hold in its second cycle
    step(JALR);
    step(8'h00);
    repeat (3) step(8'h00);
    step(JALR);
    step(RCV);
    repeat (4) step(8'h00);
    // Watchdog
    step(8'h00, 1'b1);
    repeat (TO) step(TDH);
    repeat (3) step(8'h00);
    // Perf counter saturation, then a mid-stream async reset
    repeat (20) step(IMEM);
    step(8'h00);
    step(IMEM, 1'b1);
    step(IMEM);
    step(8'h00);
    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      for (int b = 0; b < 8; b++) v[b] = ($urandom_range(0, 5) == 0);
      step(v, $urandom_range(0, 99) == 0);
    end
    step(8'h00);
    // Drain the scoreboard, bounded
    for (int k = 0; k < 5 && exp_q.size() != 0; k++) @(negedge clock);
    @(posedge clock);
    if (exp_q.size() != 0) begin
      n_chk++;
      $display("FAIL drain: %0d responses left, required 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
